alu_uart_sequencer: RTL and testbench

//  Command sequencer placed between the UART RX/TX cores and the combinational ALU.
//  - Collects three received bytes, in order: operand A, operand B, opcode.
//  - Drives the ALU operand and opcode registers from those bytes.
//  - Returns the ALU result to the UART TX core and waits for it to finish sending.
//  - Replaces the push-button loading path: the board is driven entirely from the serial link.

---
 rtl/alu_uart_sequencer_pkg.sv | 22 ++
 rtl/alu_uart_sequencer_if.sv | 28 ++
 rtl/alu_uart_sequencer.sv | 84 ++++++++
 tb/tb_alu_uart_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_sequencer_pkg.sv
// alu_uart_sequencer_pkg: shared widths, ALU opcodes and sequencer state encodings.
package alu_uart_sequencer_pkg;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    localparam logic [NB_OP-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP-1:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;
endpackage

// File: rtl/alu_uart_sequencer_if.sv
// alu_uart_sequencer_if: UART/ALU side signals of the command sequencer.
interface alu_uart_sequencer_if;
    import alu_uart_sequencer_pkg::*;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_operation;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;
    logic               o_overrun;
    logic [2:0]         o_state;

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_operation, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun, o_state
    );
    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_operation, o_tx_data, o_tx_start,
               o_busy, o_timeout, o_overrun, o_state
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects A, B, opcode bytes from UART RX, loads the ALU and returns its result over UART TX.
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int NB_TOUT     = 20
) (
    input logic              i_clk,
    input logic              i_reset,
    alu_uart_sequencer_if.slave bus
);
    state_t             state, state_n;
    logic [NB_TOUT-1:0] cnt, cnt_n;
    logic [NB_DATA-1:0] a_n, b_n, tx_n;
    logic [NB_OP-1:0]   op_n;
    logic               start_n, tout_n, ovr_n, expire;

    assign bus.o_state = state;
    assign bus.o_busy  = (state == SEND) || (state == WAIT_TX);
    assign expire      = cnt == NB_TOUT'(TIMEOUT_CYC - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= WAIT_A;
            cnt             <= '0;
            bus.o_data_a    <= '0;
            bus.o_data_b    <= '0;
            bus.o_operation <= '0;
            bus.o_tx_data   <= '0;
            bus.o_tx_start  <= 1'b0;
            bus.o_timeout   <= 1'b0;
            bus.o_overrun   <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bus.o_data_a    <= a_n;
            bus.o_data_b    <= b_n;
            bus.o_operation <= op_n;
            bus.o_tx_data   <= tx_n;
            bus.o_tx_start  <= start_n;
            bus.o_timeout   <= tout_n;
            bus.o_overrun   <= ovr_n;
        end
    end

    // Bytes arriving while a result is in flight are dropped but remembered as an overrun.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = bus.o_data_a;
        b_n     = bus.o_data_b;
        op_n    = bus.o_operation;
        tx_n    = bus.o_tx_data;
        start_n = 1'b0;
        tout_n  = 1'b0;
        ovr_n   = bus.o_overrun | (bus.i_rx_done & bus.o_busy);
        case (state)
            WAIT_A: if (bus.i_rx_done) begin
                a_n     = bus.i_rx_data;
                cnt_n   = '0;
                state_n = WAIT_B;
            end
            WAIT_B, WAIT_OP: if (bus.i_rx_done) begin
                b_n     = (state == WAIT_B) ? bus.i_rx_data : bus.o_data_b;
                op_n    = (state == WAIT_OP) ? bus.i_rx_data[NB_OP-1:0] : bus.o_operation;
                cnt_n   = '0;
                state_n = (state == WAIT_B) ? WAIT_OP : SEND;
            end else if (expire) begin
                cnt_n   = '0;
                tout_n  = 1'b1;
                state_n = WAIT_A;
            end else begin
                cnt_n   = cnt + 1'b1;
            end
            SEND: begin
                tx_n    = bus.i_alu_result;
                start_n = 1'b1;
                state_n = WAIT_TX;
            end
            WAIT_TX: state_n = bus.i_tx_done ? WAIT_A : WAIT_TX;
            default: state_n = WAIT_A;
        endcase
    end
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: directed and random stimulus checked each cycle against a command-level model.
module tb_alu_uart_sequencer;
    import alu_uart_sequencer_pkg::*;
    localparam int TO = 16;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   armed = 1'b0;

    alu_uart_sequencer_if bus ();
    alu_uart_sequencer #(.TIMEOUT_CYC(TO), .NB_TOUT(5)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h03: return sa >>> b;
            6'h02: return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result = alu_f(bus.o_data_a, bus.o_data_b, bus.o_operation);

    // Command-level model: how many bytes of the current command are held, and where the result is.
    int         nbytes = 0, idle = 0;
    bit         sending = 0, waiting = 0;
    logic [7:0] ma = 0, mb = 0, mtx = 0;
    logic [5:0] mop = 0;
    bit         mstart = 0, mtout = 0, movr = 0;

    always @(posedge i_clk) begin
        if (i_reset) begin
            nbytes = 0; idle = 0; sending = 0; waiting = 0;
            ma = 0; mb = 0; mop = 0; mtx = 0; mstart = 0; mtout = 0; movr = 0;
        end else begin
            mstart = 0;
            mtout = 0;
            if (sending) begin
                mtx = alu_f(ma, mb, mop);
                mstart = 1;
                sending = 0;
                waiting = 1;
                if (bus.i_rx_done) movr = 1;
            end else if (waiting) begin
                if (bus.i_rx_done) movr = 1;
                if (bus.i_tx_done) waiting = 0;
            end else if (bus.i_rx_done) begin
                if (nbytes == 0) ma = bus.i_rx_data;
                if (nbytes == 1) mb = bus.i_rx_data;
                if (nbytes == 2) begin
                    mop = bus.i_rx_data[5:0];
                    sending = 1;
                end
                nbytes = (nbytes + 1) % 3;
                idle = 0;
            end else if (nbytes > 0) begin
                if (idle == TO - 1) begin
                    nbytes = 0;
                    idle = 0;
                    mtout = 1;
                end else idle++;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) if (armed) begin
        chk("data_a", 32'(bus.o_data_a), 32'(ma));
        chk("data_b", 32'(bus.o_data_b), 32'(mb));
        chk("operation", 32'(bus.o_operation), 32'(mop));
        chk("tx_data", 32'(bus.o_tx_data), 32'(mtx));
        chk("tx_start", 32'(bus.o_tx_start), 32'(mstart));
        chk("timeout", 32'(bus.o_timeout), 32'(mtout));
        chk("overrun", 32'(bus.o_overrun), 32'(movr));
        chk("busy", 32'(bus.o_busy), 32'(sending || waiting));
        chk("state", 32'(bus.o_state), sending ? 32'd3 : waiting ? 32'd4 : 32'(nbytes));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic tx_ack();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic command(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] exp);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        chk("lat_n1_start", 32'(bus.o_tx_start), 32'd0);
        tick();
        chk("lat_n2_start", 32'(bus.o_tx_start), 32'd1);
        chk("result", 32'(bus.o_tx_data), 32'(exp));
        tick();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst_state", 32'(bus.o_state), 32'd0);
        chk("rst_outs", {bus.o_data_a, bus.o_data_b, bus.o_operation, 2'b00, bus.o_tx_data},
            32'd0);
        chk("rst_flags", {28'd0, bus.o_tx_start, bus.o_timeout, bus.o_overrun, bus.o_busy}, 32'd0);
    endtask

    initial begin
        bus.i_rx_data = 0;
        bus.i_rx_done = 0;
        bus.i_tx_done = 0;
        tick();
        armed = 1'b1;
        do_reset();
        command(8'h05, 8'h03, 8'h20, 8'h08);
        chk("t1_a", 32'(bus.o_data_a), 32'h05);
        chk("t1_op", 32'(bus.o_operation), 32'h20);
        tx_ack();
        chk("t1_idle", 32'(bus.o_state), 32'd0);
        command(8'h03, 8'h05, 8'h22, 8'hFE);
        tx_ack();
        command(8'hF0, 8'h0F, 8'h27, 8'h00);
        tx_ack();
        send_byte(8'h11);
        repeat (TO - 1) tick();
        chk("t3_pre_tout", 32'(bus.o_timeout), 32'd0);
        tick();
        chk("t3_tout", 32'(bus.o_timeout), 32'd1);
        chk("t3_state", 32'(bus.o_state), 32'd0);
        chk("t3_a_kept", 32'(bus.o_data_a), 32'h11);
        command(8'h01, 8'h02, 8'h20, 8'h03);
        tx_ack();
        send_byte(8'h22);
        repeat (TO - 1) tick();
        send_byte(8'h33);
        chk("t4_no_tout", 32'(bus.o_timeout), 32'd0);
        chk("t4_state", 32'(bus.o_state), 32'd2);
        send_byte(8'h20);
        tick();
        chk("t4_result", 32'(bus.o_tx_data), 32'h55);
        send_byte(8'hAA);
        chk("t5_ovr", 32'(bus.o_overrun), 32'd1);
        chk("t5_b_kept", 32'(bus.o_data_b), 32'h33);
        bus.i_rx_data = 8'h77;
        bus.i_rx_done = 1'b1;
        tx_ack();
        bus.i_rx_done = 1'b0;
        chk("t5_both", 32'(bus.o_state), 32'd0);
        command(8'h81, 8'h01, 8'h03, 8'hC0);
        tx_ack();
        chk("t5_ovr_sticky", 32'(bus.o_overrun), 32'd1);
        send_byte(8'h09);
        send_byte(8'h09);
        do_reset();
        command(8'h80, 8'h03, 8'h02, 8'h10);
        do_reset();
        tick();
        chk("t6_no_start", 32'(bus.o_tx_start), 32'd0);
        command(8'h0C, 8'h0A, 8'h26, 8'h06);
        tx_ack();
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
            bus.i_rx_data = ($urandom_range(0, 2) == 0) ? {2'($urandom), ops[$urandom_range(0, 7)]}
                                                        : 8'($urandom);
            bus.i_rx_done = (i % 200 > 160) ? 1'b0 : ($urandom_range(0, 3) == 0);
            bus.i_tx_done = ($urandom_range(0, 5) == 0);
            i_reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        bus.i_rx_done = 0;
        bus.i_tx_done = 0;
        i_reset = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
